// File: rtl/blob_pkg.sv
// Shared definitions for the orange blob tracker.
//   - direction encodings driven to the drive FSM
//   - tracker FSM state enum
//   - datapath widths (pixel count, x sum, x coordinate)
//   - sat_inc3: saturating increment for the 3-bit run counters
package blob_pkg;

  localparam int CNT_W = 19;
  localparam int SUM_W = 28;
  localparam int X_W   = 10;

  localparam logic [2:0] DIR_NONE   = 3'b000;
  localparam logic [2:0] DIR_LEFT   = 3'b001;
  localparam logic [2:0] DIR_CENTRE = 3'b010;
  localparam logic [2:0] DIR_RIGHT  = 3'b100;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_ACCUM,
    ST_DIVIDE,
    ST_UPDATE
  } state_t;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (&v) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// The start cycle itself produces the first bit, so a start seen on edge N
// gives done (and a stable quotient) after edge N+SUM_W-1: SUM_W cycles total.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               begin a division (ignored while busy)
//   dividend [SUM_W]    numerator, sampled on start
//   divisor  [CNT_W]    denominator, sampled on start (must be non-zero)
//   busy                division in progress
//   done                one-cycle pulse, quotient valid from then on
//   quotient [SUM_W]    floor(dividend / divisor), held until next start
module serial_divider
  import blob_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] quotient
);

  logic [CNT_W-1:0] rem;
  logic [SUM_W-1:0] dq;      // dividend bits shift out the top, quotient bits in the bottom
  logic [CNT_W-1:0] dvs_r;
  logic [4:0]       cnt;

  // One restoring step: returns {remainder, dividend/quotient shift register}.
  function automatic logic [CNT_W+SUM_W-1:0] div_step(
    input logic [CNT_W-1:0] r,
    input logic [SUM_W-1:0] d,
    input logic [CNT_W-1:0] v
  );
    logic [CNT_W:0] trial;
    logic           qb;
    trial = {r, d[SUM_W-1]};
    qb    = (trial >= {1'b0, v});
    if (qb) trial = trial - {1'b0, v};
    return {trial[CNT_W-1:0], d[SUM_W-2:0], qb};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   <= '0;
      dq    <= '0;
      dvs_r <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        {rem, dq} <= div_step('0, dividend, divisor);
        dvs_r     <= divisor;
        cnt       <= 5'(SUM_W - 1);
        busy      <= 1'b1;
      end else if (busy) begin
        {rem, dq} <= div_step(rem, dq, dvs_r);
        cnt       <= cnt - 5'd1;
        if (cnt == 5'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = dq;

endmodule

// File: rtl/orange_blob_tracker.sv
// Per-frame orange blob tracker. Counts orange pixels and sums their x
// positions over a frame, divides at frame end (vsync falling edge) to get a
// horizontal centroid, and produces a debounced detection flag and a one-hot
// direction for the drive FSM.
// Ports:
//   clk, rst_n        25 MHz VGA clock, async active-low reset
//   active            VGA visible area
//   vsync             VGA vsync, active-low
//   is_orange         per-pixel orange flag, valid with active
//   orange_detected   debounced detection
//   direction         001 LEFT, 010 CENTRE, 100 RIGHT, 000 NONE
//   centroid_x        last centroid
//   pixel_count       last frame's orange-pixel count
//   frame_valid       one-cycle pulse after each output update
module orange_blob_tracker
  import blob_pkg::*;
#(
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned LEFT_BOUND    = 213,
  parameter int unsigned RIGHT_BOUND   = 427,
  parameter int unsigned MIN_PIXELS    = 400,
  parameter int unsigned DETECT_FRAMES = 3,
  parameter int unsigned LOSS_FRAMES   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             active,
  input  logic             vsync,
  input  logic             is_orange,
  output logic             orange_detected,
  output logic [2:0]       direction,
  output logic [X_W-1:0]   centroid_x,
  output logic [CNT_W-1:0] pixel_count,
  output logic             frame_valid
);

  state_t           state;
  logic [X_W-1:0]   x_cnt;
  logic             vsync_q;
  logic [CNT_W-1:0] count, op_count;
  logic [SUM_W-1:0] sum_x, op_sum;
  logic [2:0]       hit_run, miss_run;
  logic             div_start, div_busy, div_done;
  logic [SUM_W-1:0] quotient;

  logic             fe, pix;
  logic [CNT_W-1:0] count_inc;
  logic [SUM_W:0]   sum_wide;
  logic [SUM_W-1:0] sum_inc;
  logic             hit, det_nx;
  logic [2:0]       hit_nx, miss_nx, dir_nx;
  logic [X_W-1:0]   cx_nx;

  // Only the low X_W quotient bits form the centroid; busy is not needed
  // because the FSM never issues a start while a division is running.
  logic unused_div;
  assign unused_div = &{1'b0, div_busy, quotient[SUM_W-1:X_W]};

  assign fe        = vsync_q & ~vsync;
  assign pix       = active & is_orange;
  assign count_inc = (&count) ? count : count + CNT_W'(1);
  assign sum_wide  = {1'b0, sum_x} + {{(SUM_W + 1 - X_W){1'b0}}, x_cnt};
  assign sum_inc   = sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt   <= '0;
      vsync_q <= 1'b1;
    end else begin
      vsync_q <= vsync;
      if (!active)                            x_cnt <= '0;
      else if (x_cnt != X_W'(H_ACTIVE - 1))   x_cnt <= x_cnt + X_W'(1);
    end
  end

  // Results of the frame currently sitting in the operand registers.
  always_comb begin
    hit     = (op_count >= CNT_W'(MIN_PIXELS));
    hit_nx  = hit ? sat_inc3(hit_run) : 3'd0;
    miss_nx = hit ? 3'd0 : sat_inc3(miss_run);
    det_nx  = orange_detected;
    if (hit && hit_nx >= 3'(DETECT_FRAMES))        det_nx = 1'b1;
    else if (!hit && miss_nx >= 3'(LOSS_FRAMES))   det_nx = 1'b0;
    cx_nx   = (op_count == '0) ? '0 : quotient[X_W-1:0];
    dir_nx  = direction;   // miss frame while still detected: hold
    if (!det_nx)                              dir_nx = DIR_NONE;
    else if (hit) begin
      if (cx_nx < X_W'(LEFT_BOUND))           dir_nx = DIR_LEFT;
      else if (cx_nx >= X_W'(RIGHT_BOUND))    dir_nx = DIR_RIGHT;
      else                                    dir_nx = DIR_CENTRE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_SYNC;
      count           <= '0;
      sum_x           <= '0;
      op_count        <= '0;
      op_sum          <= '0;
      div_start       <= 1'b0;
      hit_run         <= '0;
      miss_run        <= '0;
      orange_detected <= 1'b0;
      direction       <= DIR_NONE;
      centroid_x      <= '0;
      pixel_count     <= '0;
      frame_valid     <= 1'b0;
    end else begin
      div_start   <= 1'b0;
      frame_valid <= 1'b0;
      // Every frame end restarts accumulation, whether or not the frame is used.
      if (fe || state == ST_SYNC) begin
        count <= '0;
        sum_x <= '0;
      end else if (pix) begin
        count <= count_inc;
        sum_x <= sum_inc;
      end
      case (state)
        ST_SYNC:   if (fe) state <= ST_ACCUM;
        ST_ACCUM: begin
          if (fe) begin
            op_count <= count;
            op_sum   <= sum_x;
            if (count == '0) state <= ST_UPDATE;
            else begin
              div_start <= 1'b1;
              state     <= ST_DIVIDE;
            end
          end
        end
        ST_DIVIDE: if (div_done) state <= ST_UPDATE;
        ST_UPDATE: begin
          pixel_count     <= op_count;
          centroid_x      <= cx_nx;
          hit_run         <= hit_nx;
          miss_run        <= miss_nx;
          orange_detected <= det_nx;
          direction       <= dir_nx;
          frame_valid     <= 1'b1;
          state           <= ST_ACCUM;
        end
        default:   state <= ST_SYNC;
      endcase
    end
  end

  serial_divider u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (op_sum),
    .divisor  (op_count),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

endmodule

// File: tb/tb_orange_blob_tracker.sv
module tb_orange_blob_tracker;

  logic        clk = 1'b0;
  logic        rst_n, active, vsync, is_orange;
  logic        orange_detected, frame_valid;
  logic [2:0]  direction;
  logic [9:0]  centroid_x;
  logic [18:0] pixel_count;

  orange_blob_tracker dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .active          (active),
    .vsync           (vsync),
    .is_orange       (is_orange),
    .orange_detected (orange_detected),
    .direction       (direction),
    .centroid_x      (centroid_x),
    .pixel_count     (pixel_count),
    .frame_valid     (frame_valid)
  );

  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One frame of stimulus and its required result.
  typedef struct {
    int         nlines, x0, w, drop;
    int         cnt, cx;
    bit         det;
    logic [2:0] dir;
  } vec_t;

  typedef struct {
    int         cnt, cx;
    bit         det;
    logic [2:0] dir;
    int         e;      // cycle in which the vsync falling edge is seen
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0, errors = 0, fv_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void add(int nl, int x0, int w, int drop, int cnt, int cx,
                              bit det, logic [2:0] dir);
    vecs.push_back('{nl, x0, w, drop, cnt, cx, det, dir});
  endfunction

  // Scoreboard consumer: every frame_valid pulse must match the oldest push.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && frame_valid === 1'b1) begin
      fv_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_valid: got pulse required none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("pixel_count", 32'(pixel_count), e.cnt);
        check("centroid_x", 32'(centroid_x), e.cx);
        check("orange_detected", 32'(orange_detected), 32'(e.det));
        check("direction", 32'(direction), 32'(e.dir));
        check("latency", cyc - e.e, (e.cnt == 0) ? 2 : 31);
      end
    end
  end

  task automatic drive_lines(input vec_t v);
    for (int l = 0; l < v.nlines; l++) begin
      for (int x = 0; x < v.x0 + v.w; x++) begin
        @(negedge clk);
        active    = 1'b1;
        is_orange = (x >= v.x0) && (l < v.nlines - 1 || x < v.x0 + v.w - v.drop);
      end
      @(negedge clk);
      active    = 1'b0;
      is_orange = 1'b0;
    end
  endtask

  task automatic send_frame(input vec_t v, input bit push);
    drive_lines(v);
    @(negedge clk);
    vsync = 1'b0;
    if (push) sb.push_back('{cnt: v.cnt, cx: v.cx, det: v.det, dir: v.dir, e: cyc});
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  initial begin
    #6000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t empty, left, right;
    int   e, seen;
    empty = '{0, 0, 0, 0, 0, 0, 1'b0, 3'b000};
    left  = '{10, 80, 50, 0, 500, 104, 1'b0, 3'b000};
    right = '{10, 480, 50, 0, 500, 504, 1'b0, 3'b000};

    // blob positions, loss hysteresis, threshold edge, alternating frames
    add(10, 80, 50, 0, 500, 104, 0, 3'b000);
    add(10, 80, 50, 0, 500, 104, 0, 3'b000);
    add(10, 80, 50, 0, 500, 104, 1, 3'b001);
    add(10, 480, 50, 0, 500, 504, 1, 3'b100);
    add(10, 295, 50, 0, 500, 319, 1, 3'b010);
    repeat (4) add(0, 0, 0, 0, 0, 0, 1, 3'b010);
    add(0, 0, 0, 0, 0, 0, 0, 3'b000);
    repeat (10) add(8, 80, 50, 1, 399, 104, 0, 3'b000);
    add(8, 80, 50, 0, 400, 104, 0, 3'b000);
    add(8, 80, 50, 0, 400, 104, 0, 3'b000);
    add(8, 80, 50, 0, 400, 104, 1, 3'b001);
    repeat (4) add(0, 0, 0, 0, 0, 0, 1, 3'b001);
    add(0, 0, 0, 0, 0, 0, 0, 3'b000);
    for (int i = 0; i < 5; i++)
      if (i % 2 == 0) add(8, 80, 50, 0, 400, 104, 0, 3'b000);
      else            add(0, 0, 0, 0, 0, 0, 0, 3'b000);
    add(8, 80, 50, 0, 400, 104, 0, 3'b000);
    add(8, 80, 50, 0, 400, 104, 1, 3'b001);

    rst_n = 1'b0; active = 1'b0; vsync = 1'b1; is_orange = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_detected", 32'(orange_detected), 0);
    check("reset_direction", 32'(direction), 0);
    check("reset_centroid", 32'(centroid_x), 0);
    check("reset_count", 32'(pixel_count), 0);
    check("reset_frame_valid", 32'(frame_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);

    send_frame(empty, 1'b0);   // first frame end only leaves SYNC
    foreach (vecs[i]) send_frame(vecs[i], 1'b1);

    // reset in the middle of a division
    drive_lines(left);
    @(negedge clk);
    vsync = 1'b0;
    e = cyc;
    while (cyc < e + 10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_detected", 32'(orange_detected), 0);
    check("midrst_direction", 32'(direction), 0);
    check("midrst_centroid", 32'(centroid_x), 0);
    check("midrst_count", 32'(pixel_count), 0);
    check("midrst_frame_valid", 32'(frame_valid), 0);
    @(negedge clk);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    seen = fv_seen;
    send_frame(left, 1'b0);    // discarded: SYNC again after reset
    check("sync_discard_pulses", fv_seen - seen, 0);
    send_frame(right, 1'b1);

    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
